// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 packet receiver: FSM encoding, frame
// constants and default timeout lengths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_PARITY,
        ST_STOP,
        ST_CHECK
    } ps2_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam int   BIT_TO_DEF  = 3400;
    localparam int   BYTE_TO_DEF = 20000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_packet_rx_if.sv
// Bus bundle between the PS/2 pins/enable and the packet consumer.
interface ps2_packet_rx_if #(
    parameter int NBYTES = 3
);
    logic                  ps2_clk;
    logic                  ps2_data;
    logic                  en;
    logic [8*NBYTES-1:0]   packet;
    logic                  packet_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  timeout_err;
    logic [1:0]            byte_idx;

    modport master (
        output ps2_clk, ps2_data, en,
        input  packet, packet_valid, parity_err, frame_err, timeout_err, byte_idx
    );

    modport slave (
        input  ps2_clk, ps2_data, en,
        output packet, packet_valid, parity_err, frame_err, timeout_err, byte_idx
    );
endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data pins and flags ps2_clk falling
// edges. Flops reset to 1 so an idle bus never produces a spurious fall.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ck,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_s
);
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: frames 11-bit bytes, checks start/parity/stop,
// and assembles NBYTES bytes into one packet with bit and inter-byte timeouts.
module ps2_packet_rx
    import ps2_pkg::*;
#(
    parameter int NBYTES      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_TO      = BIT_TO_DEF,
    parameter int BYTE_TO     = BYTE_TO_DEF,
    parameter int MOUSE_SYNC  = 1
) (
    input  logic           ck,
    input  logic           reset,
    ps2_packet_rx_if.slave bus
);
    localparam int            PW       = 8 * NBYTES;
    localparam int            TW       = $clog2(max2(BIT_TO, BYTE_TO) + 1);
    localparam logic [TW-1:0] BIT_LIM  = TW'(BIT_TO);
    localparam logic [TW-1:0] BYTE_LIM = TW'(BYTE_TO);

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          stop_q, stop_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [PW-1:0] asm_q, asm_d;
    logic [PW-1:0] packet_q, packet_d;
    logic          packet_valid_q, packet_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic [TW-1:0] bit_tmr_q, bit_tmr_d;
    logic [TW-1:0] byte_tmr_q, byte_tmr_d;
    logic          clk_fall, data_s;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .ck       (ck),
        .reset    (reset),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .clk_fall (clk_fall),
        .data_s   (data_s)
    );

    always_comb begin
        state_d        = state_q;
        bitcnt_d       = bitcnt_q;
        shreg_d        = shreg_q;
        par_d          = par_q;
        stop_d         = stop_q;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        packet_d       = packet_q;
        packet_valid_d = 1'b0;
        parity_err_d   = 1'b0;
        frame_err_d    = 1'b0;
        timeout_err_d  = 1'b0;
        bit_tmr_d      = bit_tmr_q;
        byte_tmr_d     = byte_tmr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (clk_fall && data_s == START_BIT) begin
                    state_d    = ST_RECV;
                    bitcnt_d   = '0;
                    bit_tmr_d  = '0;
                    byte_tmr_d = '0;
                end else if (byte_idx_q != 2'd0 && byte_tmr_q != BYTE_LIM) begin
                    byte_tmr_d = byte_tmr_q + TW'(1);
                    if (byte_tmr_d == BYTE_LIM) begin
                        timeout_err_d = 1'b1;
                        byte_idx_d    = 2'd0;
                    end
                end
            end
            ST_RECV: begin
                if (clk_fall) begin
                    shreg_d  = {data_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    stop_d  = data_s;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (stop_q != STOP_BIT) begin
                    frame_err_d = 1'b1;
                    byte_idx_d  = 2'd0;
                end else if (!(^{shreg_q, par_q})) begin
                    parity_err_d = 1'b1;
                    byte_idx_d   = 2'd0;
                end else if (MOUSE_SYNC != 0 && byte_idx_q == 2'd0 && !shreg_q[3]) begin
                    frame_err_d = 1'b1;
                    byte_idx_d  = 2'd0;
                end else begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (byte_idx_q == 2'(i)) asm_d[8*i +: 8] = shreg_q;
                    end
                    if (byte_idx_q == 2'(NBYTES - 1)) begin
                        byte_idx_d     = 2'd0;
                        packet_d       = asm_d;
                        packet_valid_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fall in the expiry cycle wins: the timer clears instead of firing.
        if (state_q inside {ST_RECV, ST_PARITY, ST_STOP}) begin
            if (clk_fall) begin
                bit_tmr_d = '0;
            end else if (bit_tmr_q != BIT_LIM) begin
                bit_tmr_d = bit_tmr_q + TW'(1);
                if (bit_tmr_d == BIT_LIM) begin
                    timeout_err_d = 1'b1;
                    byte_idx_d    = 2'd0;
                    state_d       = ST_IDLE;
                end
            end
        end

        if (!bus.en) begin
            state_d        = ST_IDLE;
            byte_idx_d     = 2'd0;
            bit_tmr_d      = '0;
            byte_tmr_d     = '0;
            asm_d          = asm_q;
            packet_d       = packet_q;
            packet_valid_d = 1'b0;
            parity_err_d   = 1'b0;
            frame_err_d    = 1'b0;
            timeout_err_d  = 1'b0;
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bitcnt_q       <= '0;
            shreg_q        <= '0;
            par_q          <= 1'b0;
            stop_q         <= 1'b0;
            byte_idx_q     <= '0;
            asm_q          <= '0;
            packet_q       <= '0;
            packet_valid_q <= 1'b0;
            parity_err_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            bit_tmr_q      <= '0;
            byte_tmr_q     <= '0;
        end else begin
            state_q        <= state_d;
            bitcnt_q       <= bitcnt_d;
            shreg_q        <= shreg_d;
            par_q          <= par_d;
            stop_q         <= stop_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            packet_q       <= packet_d;
            packet_valid_q <= packet_valid_d;
            parity_err_q   <= parity_err_d;
            frame_err_q    <= frame_err_d;
            timeout_err_q  <= timeout_err_d;
            bit_tmr_q      <= bit_tmr_d;
            byte_tmr_q     <= byte_tmr_d;
        end
    end

    assign bus.packet       = packet_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.parity_err   = parity_err_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.byte_idx     = byte_idx_q;
endmodule

// File: tb/tb_ps2_packet_rx.sv
// Bench for ps2_packet_rx: a 3-byte mouse receiver and a 1-byte keyboard
// receiver share the same PS/2 lines and are checked against a frame-level model.
module tb_ps2_packet_rx;
    logic ck = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_r = 1'b1;
    logic ps2_data_r = 1'b1;
    logic en_r = 1'b1;

    always #5 ck = ~ck;

    ps2_packet_rx_if #(.NBYTES(3)) bus3 ();
    ps2_packet_rx_if #(.NBYTES(1)) bus1 ();

    assign bus3.ps2_clk  = ps2_clk_r;
    assign bus3.ps2_data = ps2_data_r;
    assign bus3.en       = en_r;
    assign bus1.ps2_clk  = ps2_clk_r;
    assign bus1.ps2_data = ps2_data_r;
    assign bus1.en       = en_r;

    ps2_packet_rx #(.NBYTES(3), .MOUSE_SYNC(1)) dut3 (.ck(ck), .reset(reset), .bus(bus3));
    ps2_packet_rx #(.NBYTES(1), .MOUSE_SYNC(0)) dut1 (.ck(ck), .reset(reset), .bus(bus1));

    // event kinds: 1 packet, 2 parity, 3 frame, 4 timeout
    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] pkt;
    } ev_t;

    ev_t         evq[$];
    int          tests = 0;
    int          fails = 0;
    int          m_idx[2];
    logic [31:0] m_asm[2];
    logic [31:0] vis[2];
    int          nb[2] = '{3, 1};
    bit          msync[2] = '{1'b1, 1'b0};
    int          hh = 15;

    task automatic cyc(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic push(input int u, input int kind, input logic [31:0] pkt);
        ev_t e;
        e.dut = u; e.kind = kind; e.pkt = pkt;
        evq.push_back(e);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        logic p;
        p = ~(^d) ^ par_bad;
        return {~stop_bad, p, d, 1'b0};
    endfunction

    // Frame-level outcome of one complete byte for each receiver.
    task automatic predict(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        for (int u = 0; u < 2; u++) begin
            if (stop_bad) begin
                push(u, 3, 0); m_idx[u] = 0;
            end else if (par_bad) begin
                push(u, 2, 0); m_idx[u] = 0;
            end else if (msync[u] && m_idx[u] == 0 && !d[3]) begin
                push(u, 3, 0); m_idx[u] = 0;
            end else begin
                if (m_idx[u] == 0) m_asm[u] = '0;
                m_asm[u] = m_asm[u] | (32'(d) << (8 * m_idx[u]));
                m_idx[u]++;
                if (m_idx[u] == nb[u]) begin
                    m_idx[u] = 0;
                    push(u, 1, m_asm[u]);
                end
            end
        end
    endtask

    task automatic wire_bits(input logic [10:0] w, input int from, input int to);
        for (int i = from; i < to; i++) begin
            ps2_data_r = w[i];
            cyc(hh);
            ps2_clk_r = 1'b0;
            cyc(hh);
            ps2_clk_r = 1'b1;
        end
        ps2_data_r = 1'b1;
    endtask

    function automatic int idx_of(input int u);
        return (u == 0) ? int'(bus3.byte_idx) : int'(bus1.byte_idx);
    endfunction

    task automatic settle();
        for (int u = 0; u < 2; u++) begin
            int pend;
            pend = 0;
            foreach (evq[i]) if (evq[i].dut == u) pend++;
            chk($sformatf("pending_events_dut%0d", u), 32'(pend), 32'd0);
            chk($sformatf("byte_idx_dut%0d", u), 32'(idx_of(u)), 32'(m_idx[u]));
        end
        evq.delete();
    endtask

    task automatic send(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        predict(d, par_bad, stop_bad);
        wire_bits(mk(d, par_bad, stop_bad), 0, 11);
        cyc(10);
        settle();
    endtask

    task automatic idle_long(input int n);
        for (int u = 0; u < 2; u++)
            if (m_idx[u] != 0 && n >= 20000) begin
                push(u, 4, 0); m_idx[u] = 0;
            end
        cyc(n);
        settle();
    endtask

    task automatic check_dut(input int u, input logic pv, input logic pe, input logic fe,
                             input logic te, input logic [31:0] pk);
        int cnt, kind, k;
        cnt = int'(pv) + int'(pe) + int'(fe) + int'(te);
        if (cnt == 0) begin
            chk($sformatf("packet_hold_dut%0d", u), pk, vis[u]);
            return;
        end
        kind = pv ? 1 : pe ? 2 : fe ? 3 : 4;
        chk($sformatf("single_pulse_dut%0d", u), 32'(cnt), 32'd1);
        k = -1;
        foreach (evq[i]) if (k < 0 && evq[i].dut == u) k = i;
        tests++;
        if (k < 0) begin
            fails++;
            $display("FAIL unexpected_pulse_dut%0d: got kind %0d, expected no pulse", u, kind);
            return;
        end
        if (evq[k].kind != kind) begin
            fails++;
            $display("FAIL pulse_kind_dut%0d: got kind %0d, expected kind %0d", u, kind, evq[k].kind);
        end else if (kind == 1) begin
            chk($sformatf("packet_value_dut%0d", u), pk, evq[k].pkt);
            vis[u] = evq[k].pkt;
        end
        evq.delete(k);
    endtask

    initial begin
        vis[0] = '0; vis[1] = '0;
        forever begin
            @(negedge ck);
            if (reset) begin
                vis[0] = '0; vis[1] = '0;
            end else begin
                check_dut(0, bus3.packet_valid, bus3.parity_err, bus3.frame_err,
                          bus3.timeout_err, 32'(bus3.packet));
                check_dut(1, bus1.packet_valid, bus1.parity_err, bus1.frame_err,
                          bus1.timeout_err, 32'(bus1.packet));
            end
        end
    end

    initial begin
        logic [10:0] w;
        m_idx[0] = 0; m_idx[1] = 0; m_asm[0] = '0; m_asm[1] = '0;
        #2;
        chk("reset_packet3", 32'(bus3.packet), 32'h0);
        chk("reset_flags3", 32'({bus3.packet_valid, bus3.parity_err, bus3.frame_err,
                                 bus3.timeout_err, bus3.byte_idx}), 32'h0);
        chk("reset_packet1", 32'(bus1.packet), 32'h0);
        cyc(5);
        reset = 1'b0;
        cyc(5);

        chk("frame_08", 32'(mk(8'h08, 0, 0)), 32'h410);
        chk("frame_05", 32'(mk(8'h05, 0, 0)), 32'h60A);
        chk("frame_FB", 32'(mk(8'hFB, 0, 0)), 32'h5F6);

        send(8'h08, 0, 0); send(8'h05, 0, 0); send(8'hFB, 0, 0);
        chk("mouse_packet", 32'(bus3.packet), 32'h00FB0508);
        chk("kbd_last", 32'(bus1.packet), 32'hFB);

        send(8'h5A, 1, 0);
        chk("parity_idx", 32'(bus3.byte_idx), 32'd0);
        chk("parity_hold", 32'(bus3.packet), 32'h00FB0508);
        send(8'h28, 0, 0); send(8'h11, 0, 0); send(8'h22, 0, 0);
        chk("after_parity", 32'(bus3.packet), 32'h00221128);

        send(8'h08, 0, 1);
        send(8'h00, 0, 0);
        chk("sync_drop_idx", 32'(bus3.byte_idx), 32'd0);
        chk("kbd_zero", 32'(bus1.packet), 32'h00);

        push(0, 4, 0); push(1, 4, 0); m_idx[0] = 0; m_idx[1] = 0;
        wire_bits(mk(8'hA7, 0, 0), 0, 6);
        cyc(3500);
        settle();
        send(8'h09, 0, 0); send(8'h10, 0, 0); send(8'h20, 0, 0);
        chk("after_bit_to", 32'(bus3.packet), 32'h00201009);

        send(8'h08, 0, 0); send(8'h33, 0, 0);
        chk("two_bytes_idx", 32'(bus3.byte_idx), 32'd2);
        idle_long(20100);
        chk("byte_to_idx", 32'(bus3.byte_idx), 32'd0);
        send(8'h18, 0, 0); send(8'h01, 0, 0); send(8'h02, 0, 0);
        chk("after_byte_to", 32'(bus3.packet), 32'h00020118);

        send(8'h1C, 0, 0);
        chk("kbd_1C", 32'(bus1.packet), 32'h1C);
        chk("mouse_idx_1", 32'(bus3.byte_idx), 32'd1);

        w = mk(8'h2D, 0, 0);
        wire_bits(w, 0, 4);
        en_r = 1'b0;
        m_idx[0] = 0; m_idx[1] = 0;
        wire_bits(w, 4, 11);
        cyc(10);
        chk("en_idx3", 32'(bus3.byte_idx), 32'd0);
        chk("en_idx1", 32'(bus1.byte_idx), 32'd0);
        en_r = 1'b1;
        cyc(5);
        settle();

        w = mk(8'h08, 0, 0);
        wire_bits(w, 0, 5);
        reset = 1'b1;
        #2;
        chk("midrst_packet3", 32'(bus3.packet), 32'h0);
        chk("midrst_flags3", 32'({bus3.packet_valid, bus3.parity_err, bus3.frame_err,
                                  bus3.timeout_err, bus3.byte_idx}), 32'h0);
        chk("midrst_packet1", 32'(bus1.packet), 32'h0);
        wire_bits(w, 5, 11);
        cyc(2);
        reset = 1'b0;
        m_idx[0] = 0; m_idx[1] = 0;
        cyc(5);
        settle();

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit pb, sb;
            d  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) d[3] = 1'b1;
            pb = ($urandom_range(0, 9) == 0);
            sb = ($urandom_range(0, 14) == 0);
            hh = $urandom_range(8, 25);
            send(d, pb, sb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
